divider_seq_ctrl: RTL and testbench

DIVIDER_SEQ_CTRL -- requirements
Module: divider_seq_ctrl

---
 rtl/divider_pkg.sv | 15 +
 rtl/divider_seq_row.sv | 35 +++
 rtl/divider_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_divider_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared defaults and state encoding for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

  localparam int WIDTH_DEF        = 8;
  localparam int APPROX_ITERS_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_seq_row.sv
// One WIDTH-cell ripple subtract row (w_lo - dvs), exact or approximate cells per row.
// Latency: purely combinational.
// Backpressure: none; the controller holds the operands stable.
module divider_seq_row
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] w_lo,
  input  logic [WIDTH-1:0] dvs,
  input  logic             approx,
  output logic [WIDTH-1:0] diff,
  output logic             bout_final
);

  logic [WIDTH:0] brw;

  // Borrow ripple from bit 0 upward; the approximate cell forwards the divisor bit as borrow.
  always_comb begin
    brw  = '0;
    diff = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (approx) begin
        diff[k]    = w_lo[k] | dvs[k] | ~brw[k];
        brw[k + 1] = dvs[k];
      end else begin
        diff[k]    = w_lo[k] ^ dvs[k] ^ brw[k];
        brw[k + 1] = (~w_lo[k] & dvs[k]) | (~(w_lo[k] ^ dvs[k]) & brw[k]);
      end
    end
  end

  assign bout_final = brw[WIDTH];

endmodule

// File: rtl/divider_seq_ctrl.sv
// Sequential restoring divider (2W/W), one quotient bit per cycle, optional approximate low rows.
// Latency: out_valid rises WIDTH+1 cycles after the accepting edge.
// Backpressure: results held until out_ready; in_ready only in IDLE, no operand queueing.
module divider_seq_ctrl
  import divider_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int APPROX_ITERS = APPROX_ITERS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   d,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               dz,
  output logic               ovf
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] n_lo;
  logic [WIDTH-1:0] d_q;
  logic             ae_q;
  logic             dz_q;
  logic             ovf_q;

  logic [WIDTH:0]   w_cur;
  logic             row_approx;
  logic [WIDTH-1:0] row_diff;
  logic             row_bout;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  assign in_ready   = (state == ST_IDLE);
  assign w_cur      = {rem, n_lo[idx]};
  assign row_approx = ae_q && (int'(idx) < APPROX_ITERS);

  divider_seq_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .w_lo       (w_cur[WIDTH-1:0]),
    .dvs        (d_q),
    .approx     (row_approx),
    .diff       (row_diff),
    .bout_final (row_bout)
  );

  // Quotient bit, restored/updated partial remainder and the quotient with this bit merged in.
  always_comb begin
    q_bit       = w_cur[WIDTH] | ~row_bout;
    rem_next    = q_bit ? row_diff : w_cur[WIDTH-1:0];
    q_next      = q_acc;
    q_next[idx] = q_bit;
  end

  // Control FSM, iteration datapath and result registers; outputs only move on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      rem       <= '0;
      q_acc     <= '0;
      n_lo      <= '0;
      d_q       <= '0;
      ae_q      <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      q         <= '0;
      r         <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            n_lo  <= n[WIDTH-1:0];
            d_q   <= d;
            ae_q  <= approx_en;
            rem   <= n[2*WIDTH-1:WIDTH];
            idx   <= IW'(WIDTH - 1);
            q_acc <= '0;
            dz_q  <= (d == '0);
            ovf_q <= (n[2*WIDTH-1:WIDTH] >= d);
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          rem   <= rem_next;
          q_acc <= q_next;
          if (idx == '0) begin
            q     <= q_next;
            r     <= rem_next;
            dz    <= dz_q;
            ovf   <= ovf_q;
            state <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          // Result registers settle one cycle before out_valid is raised.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Self-checking bench for divider_seq_ctrl: arithmetic reference model plus directed literals.
// Latency: checks out_valid timing against the accept edge.
// Backpressure: exercises held out_ready and ignored in_valid while busy.
module tb_divider_seq_ctrl;

  localparam int W  = 8;
  localparam int AI = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] n;
  logic [W-1:0]   d;
  logic           approx_en;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           dz;
  logic           ovf;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  divider_seq_ctrl #(
    .WIDTH        (W),
    .APPROX_ITERS (AI)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference division: long division on integers for exact rows, bit-level cell rule for approximate rows.
  function automatic logic [2*W-1:0] ref_div(input logic [2*W-1:0] nn, input logic [W-1:0] dd,
                                             input logic ae);
    logic [W-1:0] rr;
    logic [W-1:0] qq;
    logic [W:0]   wv;
    logic [W-1:0] df;
    logic         b;
    rr = nn[2*W-1:W];
    qq = '0;
    for (int i = W - 1; i >= 0; i--) begin
      wv = {rr, nn[i]};
      if (ae && i < AI) begin
        b = 1'b0;
        for (int k = 0; k < W; k++) begin
          df[k] = wv[k] | dd[k] | ~b;
          b     = dd[k];
        end
        qq[i] = wv[W] | ~b;
        rr    = qq[i] ? df : wv[W-1:0];
      end else begin
        qq[i] = (int'(wv) >= int'(dd));
        rr    = qq[i] ? W'(int'(wv) - int'(dd)) : wv[W-1:0];
      end
    end
    return {qq, rr};
  endfunction

  // Transaction-level model: busy from accept until handshake, result visible WIDTH+1 edges after accept.
  bit           m_busy = 1'b0;
  bit           m_ov = 1'b0;
  int           m_cyc = 0;
  logic [W-1:0] m_q, m_r;
  logic         m_dz, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ov   = 1'b0;
      m_cyc  = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy     = 1'b1;
        m_cyc      = 0;
        {m_q, m_r} = ref_div(n, d, approx_en);
        m_dz       = (d == '0);
        m_ovf      = (n[2*W-1:W] >= d);
      end
    end else if (m_ov) begin
      if (out_ready) begin
        m_busy = 1'b0;
        m_ov   = 1'b0;
      end
    end else begin
      m_cyc++;
      if (m_cyc == W + 1) m_ov = 1'b1;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en && rst_n === 1'b1) begin
      chk("cyc_in_ready", in_ready, !m_busy);
      chk("cyc_out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("cyc_q", q, m_q);
        chk("cyc_r", r, m_r);
        chk("cyc_dz", dz, m_dz);
        chk("cyc_ovf", ovf, m_ovf);
      end
    end
  end

  task automatic issue(input logic [2*W-1:0] nn, input logic [W-1:0] dd, input logic ae);
    n         = nn;
    d         = dd;
    approx_en = ae;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input int hold);
    logic [W-1:0] q0, r0;
    q0 = q;
    r0 = r;
    if (hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b1;
      n         = 16'h0064;
      d         = 8'd3;
      approx_en = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
      chk("bp_q_hold", q, q0);
      chk("bp_r_hold", r, r0);
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hs_out_valid_drop", out_valid, 1'b0);
    chk("hs_in_ready_rise", in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [2*W-1:0] mres;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n = '0; d = '0; approx_en = 1'b0;

    // Pin the reference model with hand-worked results.
    mres = ref_div(16'd1000, 8'd7, 1'b0);
    chk("model_exact_1000_7", mres, {8'd142, 8'd6});
    mres = ref_div(16'h0010, 8'd1, 1'b1);
    chk("model_approx_16_1", mres, {8'h3F, 8'hFF});
    mres = ref_div(16'h0900, 8'd5, 1'b0);
    chk("model_ovf_0900_5", mres, {8'hFF, 8'h05});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", dz, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Exact 1000/7.
    @(negedge clk);
    issue(16'd1000, 8'd7, 1'b0);
    wait_result(lat);
    chk("exact_latency", lat, W + 1);
    chk("exact_q", q, 142);
    chk("exact_r", r, 6);
    chk("exact_dz", dz, 1'b0);
    chk("exact_ovf", ovf, 1'b0);
    handshake(0);

    // Approximate low rows.
    @(negedge clk);
    issue(16'h0010, 8'd1, 1'b1);
    wait_result(lat);
    chk("approx_q", q, 8'h3F);
    chk("approx_r", r, 8'hFF);
    handshake(0);

    // Same operands exact.
    @(negedge clk);
    issue(16'h0010, 8'd1, 1'b0);
    wait_result(lat);
    chk("exact16_q", q, 8'h10);
    chk("exact16_r", r, 8'h00);
    handshake(0);

    // Divide by zero.
    @(negedge clk);
    issue(16'h12AB, 8'd0, 1'b0);
    wait_result(lat);
    chk("dz_flag", dz, 1'b1);
    chk("dz_q", q, 8'hFF);
    chk("dz_r", r, 8'hAB);
    handshake(0);

    // Overflow.
    @(negedge clk);
    issue(16'h0900, 8'd5, 1'b0);
    wait_result(lat);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_q", q, 8'hFF);
    chk("ovf_r", r, 8'h05);
    handshake(0);

    // Approximate 1000/7, checked against the model only.
    @(negedge clk);
    issue(16'd1000, 8'd7, 1'b1);
    wait_result(lat);
    chk("approx1000_latency", lat, W + 1);
    handshake(0);

    // Backpressure with a stray request while busy.
    @(negedge clk);
    issue(16'd12345, 8'd100, 1'b0);
    wait_result(lat);
    chk("bp_q", q, 123);
    chk("bp_r", r, 45);
    handshake(5);
    @(posedge clk);
    #1 chk("bp_no_stray_accept", in_ready, 1'b1);

    // Reset in the middle of the iterations.
    @(negedge clk);
    issue(16'd12345, 8'd100, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_q", q, 0);
    chk("mid_rst_r", r, 0);
    chk("mid_rst_dz", dz, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(16'd1000, 8'd7, 1'b0);
    chk("post_rst_accept", in_ready, 1'b0);
    wait_result(lat);
    chk("post_rst_latency", lat, W + 1);
    chk("post_rst_q", q, 142);
    chk("post_rst_r", r, 6);
    handshake(0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
